// File: rtl/pa_pkg.sv
// Shared widths and bubble encoding for the MEM/WB pipeline register.
package pa_pkg;
    localparam int XLEN      = 32;
    localparam int ADDR_SIZE = 5;
    localparam int REG_NUM   = 1 << ADDR_SIZE;

    // An empty WB slot: not valid, no register write, payload zeroed.
    localparam logic BUBBLE_VALID = 1'b0;
    localparam logic BUBBLE_RF_WE = 1'b0;
endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM->WB stage bus. Forwarding ports exist only when WB_FWD_EN is defined.
interface mem_wb_stage_if #(
    parameter int XLEN      = pa_pkg::XLEN,
    parameter int ADDR_SIZE = pa_pkg::ADDR_SIZE
);
    logic [XLEN-1:0]      MEM_data_mem;
    logic [ADDR_SIZE-1:0] MEM_rd;
    logic                 MEM_rf_we;
    logic                 MEM_valid;
    logic                 WB_stall;
    logic                 WB_flush;
    logic [XLEN-1:0]      WB_data;
    logic [ADDR_SIZE-1:0] WB_rd;
    logic                 WB_we;
    logic                 WB_valid;
    logic [31:0]          WB_retired;
`ifdef WB_FWD_EN
    logic [ADDR_SIZE-1:0] EX_rs1;
    logic [ADDR_SIZE-1:0] EX_rs2;
    logic                 WB_fwd_a;
    logic                 WB_fwd_b;
`endif

`ifdef WB_FWD_EN
    modport master (
        output MEM_data_mem, MEM_rd, MEM_rf_we, MEM_valid, WB_stall, WB_flush,
        output EX_rs1, EX_rs2,
        input  WB_data, WB_rd, WB_we, WB_valid, WB_retired, WB_fwd_a, WB_fwd_b
    );
    modport slave (
        input  MEM_data_mem, MEM_rd, MEM_rf_we, MEM_valid, WB_stall, WB_flush,
        input  EX_rs1, EX_rs2,
        output WB_data, WB_rd, WB_we, WB_valid, WB_retired, WB_fwd_a, WB_fwd_b
    );
`else
    modport master (
        output MEM_data_mem, MEM_rd, MEM_rf_we, MEM_valid, WB_stall, WB_flush,
        input  WB_data, WB_rd, WB_we, WB_valid, WB_retired
    );
    modport slave (
        input  MEM_data_mem, MEM_rd, MEM_rf_we, MEM_valid, WB_stall, WB_flush,
        output WB_data, WB_rd, WB_we, WB_valid, WB_retired
    );
`endif
endinterface

// File: rtl/wb_fwd_unit.sv
// WB->EX forward-hit comparator; independent of the done flag so a held
// instruction keeps forwarding after its single register write.
module wb_fwd_unit #(
    parameter int ADDR_SIZE = pa_pkg::ADDR_SIZE
) (
    input  logic                 wb_valid,
    input  logic                 wb_rf_we,
    input  logic [ADDR_SIZE-1:0] wb_rd,
    input  logic [ADDR_SIZE-1:0] ex_rs1,
    input  logic [ADDR_SIZE-1:0] ex_rs2,
    output logic                 fwd_a,
    output logic                 fwd_b
);
    logic wb_live;

    always_comb begin
        wb_live = wb_valid & wb_rf_we & (wb_rd != '0);
        fwd_a   = wb_live & (wb_rd == ex_rs1);
        fwd_b   = wb_live & (wb_rd == ex_rs2);
    end
endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with stall/flush, write-once under stall and a
// retirement counter. Define WB_FWD_EN to add the WB->EX forwarding compare.
module mem_wb_stage #(
    parameter int XLEN      = pa_pkg::XLEN,
    parameter int ADDR_SIZE = pa_pkg::ADDR_SIZE
) (
    input  logic           clk,
    input  logic           rst,
    mem_wb_stage_if.slave  bus
);
    import pa_pkg::*;

    logic [XLEN-1:0]      data_q, data_d;
    logic [ADDR_SIZE-1:0] rd_q, rd_d;
    logic                 valid_q, valid_d;
    logic                 rf_we_q, rf_we_d;
    logic                 done_q, done_d;
    logic [31:0]          retired_q, retired_d;
    logic                 we;
    logic                 retire;

    always_comb begin
        we      = valid_q & rf_we_q & (rd_q != '0) & ~done_q;
        // Counted once: either when the slot moves on, or when a held
        // instruction performs its one write.
        retire  = valid_q & ~done_q & (~bus.WB_stall | we);

        data_d    = data_q;
        rd_d      = rd_q;
        valid_d   = valid_q;
        rf_we_d   = rf_we_q;
        done_d    = done_q;
        retired_d = retire ? retired_q + 32'd1 : retired_q;

        if (bus.WB_flush || (!bus.WB_stall && !bus.MEM_valid)) begin
            data_d  = '0;
            rd_d    = '0;
            valid_d = BUBBLE_VALID;
            rf_we_d = BUBBLE_RF_WE;
            done_d  = 1'b0;
        end else if (!bus.WB_stall) begin
            data_d  = bus.MEM_data_mem;
            rd_d    = bus.MEM_rd;
            valid_d = 1'b1;
            rf_we_d = bus.MEM_rf_we;
            done_d  = 1'b0;
        end else begin
            done_d  = done_q | we;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q    <= '0;
            rd_q      <= '0;
            valid_q   <= 1'b0;
            rf_we_q   <= 1'b0;
            done_q    <= 1'b0;
            retired_q <= '0;
        end else begin
            data_q    <= data_d;
            rd_q      <= rd_d;
            valid_q   <= valid_d;
            rf_we_q   <= rf_we_d;
            done_q    <= done_d;
            retired_q <= retired_d;
        end
    end

    assign bus.WB_data    = data_q;
    assign bus.WB_rd      = rd_q;
    assign bus.WB_valid   = valid_q;
    assign bus.WB_we      = we;
    assign bus.WB_retired = retired_q;

`ifdef WB_FWD_EN
    wb_fwd_unit #(.ADDR_SIZE(ADDR_SIZE)) u_fwd (
        .wb_valid (valid_q),
        .wb_rf_we (rf_we_q),
        .wb_rd    (rd_q),
        .ex_rs1   (bus.EX_rs1),
        .ex_rs2   (bus.EX_rs2),
        .fwd_a    (bus.WB_fwd_a),
        .fwd_b    (bus.WB_fwd_b)
    );
`endif
endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed table-driven bench for mem_wb_stage plus hand sequences for
// counter wrap, reset during stall and (with WB_FWD_EN) forwarding.
module tb_mem_wb_stage;
    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mem_wb_stage_if #(.XLEN(32), .ADDR_SIZE(5)) bus ();

    mem_wb_stage #(.XLEN(32), .ADDR_SIZE(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        mv;
        logic        mwe;
        logic [4:0]  mrd;
        logic [31:0] mdata;
        logic        stall;
        logic        flush;
        logic [31:0] edata;
        logic [4:0]  erd;
        logic        evalid;
        logic        ewe;
        logic [31:0] eret;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(logic mv, logic mwe, logic [4:0] mrd, logic [31:0] mdata,
                                logic stall, logic flush, logic [31:0] edata, logic [4:0] erd,
                                logic evalid, logic ewe, logic [31:0] eret);
        vec_t v;
        v.mv = mv; v.mwe = mwe; v.mrd = mrd; v.mdata = mdata;
        v.stall = stall; v.flush = flush;
        v.edata = edata; v.erd = erd; v.evalid = evalid; v.ewe = ewe; v.eret = eret;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic mv, input logic mwe, input logic [4:0] mrd,
                         input logic [31:0] mdata, input logic stall, input logic flush);
        bus.MEM_valid    = mv;
        bus.MEM_rf_we    = mwe;
        bus.MEM_rd       = mrd;
        bus.MEM_data_mem = mdata;
        bus.WB_stall     = stall;
        bus.WB_flush     = flush;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [31:0] edata, input logic [4:0] erd,
                           input logic evalid, input logic ewe, input logic [31:0] eret);
        chk({tag, ".data"},    bus.WB_data, edata);
        chk({tag, ".rd"},      {27'd0, bus.WB_rd}, {27'd0, erd});
        chk({tag, ".valid"},   {31'd0, bus.WB_valid}, {31'd0, evalid});
        chk({tag, ".we"},      {31'd0, bus.WB_we}, {31'd0, ewe});
        chk({tag, ".retired"}, bus.WB_retired, eret);
    endtask

    initial begin
        //            mv mwe rd     data           st fl  edata          erd    ev we ret
        vecs[0]  = mk(1, 1, 5'd5,  32'h1234ABCD, 0, 0, 32'h1234ABCD, 5'd5,  1, 1, 0);
        vecs[1]  = mk(0, 1, 5'd2,  32'h00000002, 0, 0, 32'h00000000, 5'd0,  0, 0, 1);
        vecs[2]  = mk(1, 1, 5'd9,  32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 5'd9,  1, 1, 1);
        vecs[3]  = mk(1, 1, 5'd3,  32'h11111111, 1, 0, 32'hDEADBEEF, 5'd9,  1, 0, 2);
        vecs[4]  = mk(1, 1, 5'd3,  32'h11111111, 1, 0, 32'hDEADBEEF, 5'd9,  1, 0, 2);
        vecs[5]  = mk(1, 1, 5'd3,  32'h11111111, 1, 0, 32'hDEADBEEF, 5'd9,  1, 0, 2);
        vecs[6]  = mk(1, 1, 5'd0,  32'h00005555, 0, 0, 32'h00005555, 5'd0,  1, 0, 2);
        vecs[7]  = mk(1, 0, 5'd12, 32'hCAFEF00D, 0, 0, 32'hCAFEF00D, 5'd12, 1, 0, 3);
        vecs[8]  = mk(0, 1, 5'd4,  32'h00000044, 0, 0, 32'h00000000, 5'd0,  0, 0, 4);
        vecs[9]  = mk(1, 1, 5'd6,  32'h00000066, 0, 0, 32'h00000066, 5'd6,  1, 1, 4);
        vecs[10] = mk(1, 1, 5'd7,  32'h00000077, 1, 1, 32'h00000000, 5'd0,  0, 0, 5);
        vecs[11] = mk(1, 1, 5'd7,  32'h00000077, 1, 0, 32'h00000000, 5'd0,  0, 0, 5);
        vecs[12] = mk(1, 1, 5'd8,  32'h00000088, 0, 1, 32'h00000000, 5'd0,  0, 0, 5);

        rst = 1'b1;
        drive(1, 1, 5'd1, 32'hFFFFFFFF, 0, 0);
`ifdef WB_FWD_EN
        bus.EX_rs1 = 5'd0;
        bus.EX_rs2 = 5'd0;
`endif
        step();
        step();
        chk_all("reset", 32'h0, 5'd0, 1'b0, 1'b0, 32'h0);

        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].mv, vecs[i].mwe, vecs[i].mrd, vecs[i].mdata, vecs[i].stall, vecs[i].flush);
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].edata, vecs[i].erd, vecs[i].evalid,
                    vecs[i].ewe, vecs[i].eret);
            @(negedge clk);
        end

        // Counter wrap: place an instruction in WB, then push the count to all ones.
        drive(1, 1, 5'd1, 32'h00000001, 0, 0);
        step();
        @(negedge clk);
        force dut.retired_q = 32'hFFFFFFFF;
        #1;
        release dut.retired_q;
        drive(0, 0, 5'd0, 32'h0, 0, 0);
        step();
        chk("wrap.retired", bus.WB_retired, 32'h0);
        chk("wrap.valid", {31'd0, bus.WB_valid}, 32'h0);

        // Reset while an instruction is held (already written and counted).
        @(negedge clk);
        drive(1, 1, 5'd5, 32'h1234ABCD, 0, 0);
        step();
        chk("hold.we_pre", {31'd0, bus.WB_we}, 32'h1);
        @(negedge clk);
        bus.WB_stall = 1'b1;
        step();
        chk("hold.retired", bus.WB_retired, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        step();
        chk_all("rst_stall", 32'h0, 5'd0, 1'b0, 1'b0, 32'h0);
        step();
        chk("rst_stall.we2", {31'd0, bus.WB_we}, 32'h0);

        // Reset while an uncounted instruction sits in WB: it is discarded.
        @(negedge clk);
        rst = 1'b0;
        drive(1, 1, 5'd10, 32'hA5A5A5A5, 0, 0);
        step();
        chk("load.rd", {27'd0, bus.WB_rd}, 32'd10);
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 5'd0, 32'h0, 0, 0);
        step();
        chk("rst_discard.retired", bus.WB_retired, 32'h0);
        chk("rst_discard.valid", {31'd0, bus.WB_valid}, 32'h0);

`ifdef WB_FWD_EN
        @(negedge clk);
        rst = 1'b0;
        drive(1, 1, 5'd7, 32'h00000070, 0, 0);
        bus.EX_rs1 = 5'd7;
        bus.EX_rs2 = 5'd3;
        step();
        chk("fwd.a_hit", {31'd0, bus.WB_fwd_a}, 32'h1);
        chk("fwd.b_miss", {31'd0, bus.WB_fwd_b}, 32'h0);
        @(negedge clk);
        bus.WB_stall = 1'b1;
        bus.EX_rs2   = 5'd7;
        step();
        chk("fwd.a_done", {31'd0, bus.WB_fwd_a}, 32'h1);
        chk("fwd.b_done", {31'd0, bus.WB_fwd_b}, 32'h1);
        @(negedge clk);
        drive(1, 1, 5'd0, 32'h00000000, 0, 0);
        bus.EX_rs1 = 5'd0;
        bus.EX_rs2 = 5'd0;
        step();
        chk("fwd.a_r0", {31'd0, bus.WB_fwd_a}, 32'h0);
        chk("fwd.b_r0", {31'd0, bus.WB_fwd_b}, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
